// File: rtl/gpr_file_sb_if.sv
// Decode/writeback-facing bundle of the register file: write, two reads, reserve, clear.
// Purely a wiring container; all timing is defined by gpr_file_sb.
// master = core side driving requests, slave = register file answering them.
interface gpr_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_ready;
    logic              rt_ready;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;
    logic              clr_start;
    logic              clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rs_addr, rt_addr, rsv_en, rsv_addr, clr_start,
        input  rs_data, rt_data, rs_ready, rt_ready, rsv_ok, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rs_addr, rt_addr, rsv_en, rsv_addr, clr_start,
        output rs_data, rt_data, rs_ready, rt_ready, rsv_ok, clr_busy
    );
endinterface

// File: rtl/gpr_file_sb.sv
// Register file with per-register pending (busy) scoreboard, write bypass and sequential clear.
// Reads/ready/rsv_ok are combinational (0 cycles); writes and reservations take effect at posedge.
// No stall path: while clearing, writes and reservations are dropped and both ready outputs are 0.
module gpr_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    gpr_file_sb_if.slave   io_gpr
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic w_idle;
    logic w_rs_zero;
    logic w_rt_zero;
    logic w_wr_zero;
    logic w_rsv_zero;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_wr_do;
    logic w_rsv_ok;

    assign w_idle     = (r_state == S_IDLE);
    assign w_rs_zero  = ZERO_R0 && (io_gpr.rs_addr  == '0);
    assign w_rt_zero  = ZERO_R0 && (io_gpr.rt_addr  == '0);
    assign w_wr_zero  = ZERO_R0 && (io_gpr.wr_addr  == '0);
    assign w_rsv_zero = ZERO_R0 && (io_gpr.rsv_addr == '0);

    // Bypass only forwards a write that will actually land this cycle.
    assign w_rs_hit = BYPASS && io_gpr.wr_en && w_idle && !w_rs_zero &&
                      (io_gpr.wr_addr == io_gpr.rs_addr);
    assign w_rt_hit = BYPASS && io_gpr.wr_en && w_idle && !w_rt_zero &&
                      (io_gpr.wr_addr == io_gpr.rt_addr);

    assign w_wr_do = w_idle && io_gpr.wr_en && !w_wr_zero;

    // A pending register may be re-reserved in the very cycle its writeback retires it.
    assign w_rsv_ok = w_idle && io_gpr.rsv_en &&
                      (w_rsv_zero || !r_busy[io_gpr.rsv_addr] ||
                       (io_gpr.wr_en && (io_gpr.wr_addr == io_gpr.rsv_addr)));

    assign io_gpr.rs_data  = w_rs_zero ? '0 : (w_rs_hit ? io_gpr.wr_data : r_regs[io_gpr.rs_addr]);
    assign io_gpr.rt_data  = w_rt_zero ? '0 : (w_rt_hit ? io_gpr.wr_data : r_regs[io_gpr.rt_addr]);
    assign io_gpr.rs_ready = w_idle && (!r_busy[io_gpr.rs_addr] || w_rs_hit);
    assign io_gpr.rt_ready = w_idle && (!r_busy[io_gpr.rt_addr] || w_rt_hit);
    assign io_gpr.rsv_ok   = w_rsv_ok;
    assign io_gpr.clr_busy = (r_state == S_CLEAR);

    // Clear-engine state and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear-engine next state: one register per cycle, leaving after the last address.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (io_gpr.clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register storage: clear sweep has priority, otherwise accept writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_do) begin
            r_regs[io_gpr.wr_addr] <= io_gpr.wr_data;
        end
    end

    // Busy bits: writeback retires, a granted reservation sets afterwards so it wins on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (r_state == S_CLEAR) begin
            r_busy[r_cnt] <= 1'b0;
        end else begin
            if (io_gpr.wr_en) begin
                r_busy[io_gpr.wr_addr] <= 1'b0;
            end
            if (w_rsv_ok && !w_rsv_zero) begin
                r_busy[io_gpr.rsv_addr] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_sb.sv
// Drives two register files (bypass / no-bypass+zero-r0) with identical stimulus.
// Expected outputs per cycle come from an array-based model and go through queues.
// A negedge monitor pops and compares every combinational and registered output.
module tb_gpr_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        drv_we = 1'b0;
    logic [3:0]  drv_wa = '0;
    logic [31:0] drv_wd = '0;
    logic [3:0]  drv_rs = '0;
    logic [3:0]  drv_rt = '0;
    logic        drv_re = 1'b0;
    logic [3:0]  drv_ra = '0;
    logic        drv_cs = 1'b0;

    gpr_file_sb_if #(.DATA_W(32), .ADDR_W(4)) if0 ();
    gpr_file_sb_if #(.DATA_W(32), .ADDR_W(4)) if1 ();

    assign if0.wr_en = drv_we;  assign if1.wr_en = drv_we;
    assign if0.wr_addr = drv_wa; assign if1.wr_addr = drv_wa;
    assign if0.wr_data = drv_wd; assign if1.wr_data = drv_wd;
    assign if0.rs_addr = drv_rs; assign if1.rs_addr = drv_rs;
    assign if0.rt_addr = drv_rt; assign if1.rt_addr = drv_rt;
    assign if0.rsv_en = drv_re;  assign if1.rsv_en = drv_re;
    assign if0.rsv_addr = drv_ra; assign if1.rsv_addr = drv_ra;
    assign if0.clr_start = drv_cs; assign if1.clr_start = drv_cs;

    gpr_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .io_gpr(if0.slave));
    gpr_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .io_gpr(if1.slave));

    typedef struct packed {
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic        rsr;
        logic        rtr;
        logic        ok;
        logic        cb;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;

    // Reference model: index 0 = bypass, no zero-r0; index 1 = no bypass, zero-r0.
    logic [31:0] m_mem [2][16];
    bit          m_busy[2][16];
    bit          m_clr [2];
    int          m_left[2];   // clear cycles still to run

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                m_mem[c][a] = '0;
                m_busy[c][a] = 1'b0;
            end
            m_clr[c] = 1'b0;
            m_left[c] = 0;
        end
    endtask

    function automatic bit is_z(int c, logic [3:0] a);
        return (c == 1) && (a == 4'd0);
    endfunction

    function automatic bit hit(int c, logic [3:0] a);
        return (c == 0) && drv_we && (drv_wa == a) && !m_clr[c] && !is_z(c, a);
    endfunction

    function automatic logic [31:0] rd(int c, logic [3:0] a);
        if (is_z(c, a)) return 32'd0;
        if (hit(c, a)) return drv_wd;
        return m_mem[c][a];
    endfunction

    function automatic logic rdy(int c, logic [3:0] a);
        return !m_clr[c] && (!m_busy[c][a] || hit(c, a));
    endfunction

    function automatic logic rsv_ok(int c);
        if (m_clr[c] || !drv_re) return 1'b0;
        if (is_z(c, drv_ra)) return 1'b1;
        return !m_busy[c][drv_ra] || (drv_we && drv_wa == drv_ra);
    endfunction

    function automatic exp_t model_out(int c);
        exp_t e;
        e.rsd = rd(c, drv_rs);
        e.rtd = rd(c, drv_rt);
        e.rsr = rdy(c, drv_rs);
        e.rtr = rdy(c, drv_rt);
        e.ok  = rsv_ok(c);
        e.cb  = m_clr[c];
        return e;
    endfunction

    task automatic model_step(int c);
        bit ok;
        int idx;
        if (rst) return;
        if (m_clr[c]) begin
            idx = 16 - m_left[c];
            m_mem[c][idx] = '0;
            m_busy[c][idx] = 1'b0;
            m_left[c]--;
            if (m_left[c] == 0) m_clr[c] = 1'b0;
            return;
        end
        ok = rsv_ok(c);
        if (drv_cs) begin
            m_clr[c] = 1'b1;
            m_left[c] = 16;
        end
        if (drv_we && !is_z(c, drv_wa)) m_mem[c][drv_wa] = drv_wd;
        if (drv_we) m_busy[c][drv_wa] = 1'b0;
        if (ok && !is_z(c, drv_ra)) m_busy[c][drv_ra] = 1'b1;
    endtask

    task automatic cyc(input bit r, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] rs, input logic [3:0] rt, input bit re,
                       input logic [3:0] ra, input bit cs);
        @(posedge clk);
        #1;
        rst = r; drv_we = we; drv_wa = wa; drv_wd = wd;
        drv_rs = rs; drv_rt = rt; drv_re = re; drv_ra = ra; drv_cs = cs;
        if (r) model_reset();
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input logic [3:0] rs, input logic [3:0] rt);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, rs, rt, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare whatever the model predicted for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0.rs_data", if0.rs_data, e.rsd);
                chk("d0.rt_data", if0.rt_data, e.rtd);
                chk("d0.rs_ready", {31'd0, if0.rs_ready}, {31'd0, e.rsr});
                chk("d0.rt_ready", {31'd0, if0.rt_ready}, {31'd0, e.rtr});
                chk("d0.rsv_ok", {31'd0, if0.rsv_ok}, {31'd0, e.ok});
                chk("d0.clr_busy", {31'd0, if0.clr_busy}, {31'd0, e.cb});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.rs_data", if1.rs_data, e.rsd);
                chk("d1.rt_data", if1.rt_data, e.rtd);
                chk("d1.rs_ready", {31'd0, if1.rs_ready}, {31'd0, e.rsr});
                chk("d1.rt_ready", {31'd0, if1.rt_ready}, {31'd0, e.rtr});
                chk("d1.rsv_ok", {31'd0, if1.rsv_ok}, {31'd0, e.ok});
                chk("d1.clr_busy", {31'd0, if1.clr_busy}, {31'd0, e.cb});
            end
        end
    end

    task automatic fill();
        for (int a = 0; a < 16; a++)
            cyc(1'b0, 1'b1, 4'(a), 32'hA500_0000 | 32'(a + 1), 4'(a), 4'(15 - a), 1'b0, 4'd0, 1'b0);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) idle(4'(a), 4'(15 - a));
    endtask

    // Stimulus: directed scenarios, clear/reset interplay, then random traffic.
    initial begin
        model_reset();
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0);
        sweep();
        // write with same-cycle read of r5
        cyc(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);
        idle(4'd5, 4'd5);
        // reservation, refused re-reservation, retiring write
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd3, 1'b1, 4'd3, 1'b0);
        idle(4'd0, 4'd3);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd3, 1'b1, 4'd3, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 32'h11, 4'd0, 4'd3, 1'b0, 4'd0, 1'b0);
        idle(4'd0, 4'd3);
        // write and reserve r7 together
        cyc(1'b0, 1'b1, 4'd7, 32'h22, 4'd7, 4'd7, 1'b1, 4'd7, 1'b0);
        idle(4'd7, 4'd7);
        // r0 write and reservation
        cyc(1'b0, 1'b1, 4'd0, 32'hFFFF, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        idle(4'd0, 4'd0);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
        idle(4'd0, 4'd0);
        // full clear with traffic that must be dropped
        fill();
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2, 1'b1, 4'd4, 1'b1);
        for (int i = 0; i < 18; i++)
            cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, 4'(i), 4'(15 - i),
                1'b1, 4'($urandom_range(0, 15)), 1'b1);
        sweep();
        // clear interrupted by reset
        fill();
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) idle(4'(i), 4'(i + 8));
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd9, 4'd10, 1'b0, 4'd0, 1'b0);
        sweep();
        // random traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] wa;
            logic [3:0] rs;
            logic [3:0] rt;
            wa = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            rt = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1), wa, $urandom, rs, rt,
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 99) == 0));
        end
        idle(4'd0, 4'd0);
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d/%0d want=0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
